axi_burst_master: RTL

Single-outstanding AXI4 master that converts a simple command/stream interface into INCR bursts. It sits directly upstream of the testbench AXI RAM model, driving its AW/W/B/AR/R channels. Testbenches and bring-up sequencers use it to load and read back memory without hand-coding AXI handshakes.

---
 rtl/axi_burst_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - single-outstanding AXI4 INCR burst master behind a command/stream front end
// Define AXI_BURST_MASTER_STATS_EN to add the beat/error statistics counters.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [1:0]            rsp_resp,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
`ifdef AXI_BURST_MASTER_STATS_EN
  ,
  output logic [31:0]           stat_wr_beats,
  output logic [31:0]           stat_rd_beats,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam int SIZE = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SIZE) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP
  } state_t;

  state_t                state, state_nxt;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]            len_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [7:0]            beat_cnt;
  logic [1:0]            resp_reg;
  logic [ID_WIDTH-1:0]   bid_reg;
  logic                  cmd_hs, w_hs, r_hs, last_w;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign w_hs   = (state == S_W) && wr_valid && m_axi_wready;
  assign r_hs   = (state == S_R) && m_axi_rvalid && rd_ready;
  assign last_w = (beat_cnt == len_reg);

  always_comb begin
    state_nxt     = state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      S_IDLE: if (cmd_hs) state_nxt = cmd_write ? S_AW : S_AR;
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_w;
        if (w_hs && last_w) state_nxt = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = S_RSP;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        // rlast alone ends the burst, whether it comes early or late
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_last      = m_axi_rlast;
        if (r_hs && m_axi_rlast) state_nxt = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      len_reg   <= '0;
      id_reg    <= '0;
      beat_cnt  <= '0;
      resp_reg  <= '0;
      bid_reg   <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      if (cmd_hs) begin
        write_reg <= cmd_write;
        addr_reg  <= cmd_addr & ALIGN_MASK;
        len_reg   <= cmd_len;
        id_reg    <= cmd_id;
      end
      if (state == S_AW || state == S_AR) beat_cnt <= '0;
      else if (w_hs || r_hs) beat_cnt <= beat_cnt + 8'd1;
      // the response register holds bresp for writes, worst rresp for reads
      if (state == S_AR) resp_reg <= 2'b00;
      else if (state == S_B && m_axi_bvalid) begin
        resp_reg <= m_axi_bresp;
        bid_reg  <= m_axi_bid;
      end else if (r_hs && (m_axi_rresp > resp_reg)) resp_reg <= m_axi_rresp;
    end
  end

  assign m_axi_awid    = id_reg;
  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = len_reg;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_arid    = id_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_arlen   = len_reg;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign rd_data       = m_axi_rdata;
  assign rsp_write     = write_reg;
  assign rsp_id        = id_reg;
  assign rsp_resp      = resp_reg;

  logic unused_ok;
  assign unused_ok = &{1'b0, m_axi_rid, bid_reg};

`ifdef AXI_BURST_MASTER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_beats <= '0;
      stat_rd_beats <= '0;
      stat_err_cnt  <= '0;
    end else begin
      if (w_hs) stat_wr_beats <= stat_wr_beats + 32'd1;
      if (r_hs) stat_rd_beats <= stat_rd_beats + 32'd1;
      if (rsp_valid && rsp_ready && (resp_reg != 2'b00)) stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule
